ram8_16: RTL and testbench
==========================

Name: ram8_16

Overview:
- 8-entry x 16-bit register bank; the storage stage directly upstream of the existing mux8way16.
- Eight 16-bit registers drive mux8way16 inputs a..h, and the address drives its select.
- Adds synchronous single-word writes and a sequenced bulk-clear sweep with a busy flag.
- Building block for the next RAM64 level.

Parameters:
- WIDTH, 16, data word width (fixed by mux8way16; do not override).
- DEPTH, 8, number of registers (fixed; address is 3 bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- d  input  16  write data
- load  input  1  write enable for the word at addr
- addr  input  3  read/write address; bit 0 = LSB; 3'b000 selects reg 0 (mux input a), 3'b111 selects reg 7 (mux input h)
- clr  input  1  one-cycle request to start a bulk-clear sweep
- y  output  16  contents of the register at addr (read path through mux8way16)
- busy  output  1  high while the clear sweep runs

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clk edge.
  - All 8 registers go to 16'h0000; busy=0; sweep pointer=0; FSM=IDLE.
  - Therefore y=16'h0000 for any addr after reset.
  - Reset overrides load and clr in the same cycle.
- Read path: combinational, zero latency; y = reg[addr] via a mux8way16 instance.
  - A change of addr alone changes y in the same cycle.
- Write: if load=1, busy=0 and clr=0 at a rising edge, then reg[addr] <= d.
  - y shows the new value from that edge onward (1-cycle write-to-read latency).
  - A read of the same address in the write cycle returns the OLD value; there is no bypass.
- FSM states:
  - IDLE: busy=0. If clr=1, go to SWEEP with ptr=0.
  - SWEEP: busy=1. Each cycle, reg[ptr] <= 0 and ptr <= ptr+1. At ptr=7, clear reg 7 and return to IDLE.
  - The sweep takes exactly 8 cycles. busy rises on the edge after clr is sampled and falls on the edge after reg 7 is cleared.
  - ptr is 3 bits and wraps 7->0 on exit; it is only meaningful in SWEEP.
- Priority and simultaneous events:
  - clr together with load in IDLE: the clear wins, the write is dropped, and the sweep starts.
  - load while busy=1: ignored, with no queueing and no error flag.
  - clr while busy=1: ignored; the sweep is not restarted or extended.
  - rst during SWEEP: abort immediately; all registers are zero anyway, and busy=0 on the next cycle.
- Reads during SWEEP are legal. They return 0 for entries already cleared (index < ptr at the sampling point) and the prior value otherwise.
- The block has no X-propagation requirement beyond inputs; addr is always fully decoded (8 of 8).

Test Plan:
1. Reset, then read all 8 addrs -> y=16'h0000 for each; busy=0.
2. Write reg i = 16'h1111*(i+1) for i=0..7 (e.g. addr=3'b010, d=16'h3333, load=1). Then read back -> y matches per addr (addr=3'b111 gives 16'h8888). A same-cycle read returns the old value.
3. Write 16'hFFFF to addr 5 with load=0 -> y at addr 5 is unchanged (16'h6666). Write 16'hABCD with load=1 -> y=16'hABCD next cycle; other addrs are unchanged.
4. With the bank preloaded as in step 2, pulse clr.
   - busy=1 for exactly 8 cycles.
   - Reading addr 7 during cycles 1-7 gives 16'h8888, then 16'h0000 after the sweep.
   - load=1, addr=0, d=16'h1234 during busy is ignored (reg 0 stays 0).
   - After busy falls, all 8 reads give 0.
5. clr=1 and load=1 (addr=2, d=16'hBEEF) in the same IDLE cycle -> sweep starts and reg 2 ends at 0. A second clr pulse at sweep cycle 4 does not extend busy: total busy stays 8 cycles.
6. Assert rst at sweep cycle 3 -> next cycle busy=0 and all reads give 0. A write of 16'h00FF to addr 4 one cycle later succeeds (y=16'h00FF).

Source files
------------

// File: rtl/ram8_16.sv
// ram8_16: eight 16-bit registers feeding a mux8way16 read path, with
// synchronous single-word writes and a sequenced 8-cycle bulk-clear sweep.

// mux8way16: combinational 8-to-1 selector of 16-bit words (a..h by sel).
module mux8way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  // Fully decoded select; 3'b000 picks a, 3'b111 picks h.
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

// Control semantics: load and clr are level samples at the rising edge, with
// no handshake back to the source. A write (load) is taken only when the bank
// is idle and no clr is present; clr is taken only when idle and starts an
// 8-cycle sweep during which busy=1 and every load/clr is dropped.
module ram8_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic [2:0]       addr,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [WIDTH-1:0] regs [DEPTH];

  // Storage, sweep pointer and control FSM; busy is registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      state <= IDLE;
      ptr   <= 3'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            // Clear wins over a simultaneous write; the write is dropped.
            state <= SWEEP;
            ptr   <= 3'd0;
            busy  <= 1'b1;
          end else if (load) begin
            regs[addr] <= d;
          end
        end
        SWEEP: begin
          regs[ptr] <= '0;
          ptr       <= ptr + 3'd1;
          if (ptr == 3'd7) begin
            // ptr wraps to 0 here; it is not used again until the next sweep.
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency read path; no write bypass, so a same-cycle read sees the old word.
  mux8way16 u_mux (
    .a   (regs[0]),
    .b   (regs[1]),
    .c   (regs[2]),
    .d   (regs[3]),
    .e   (regs[4]),
    .f   (regs[5]),
    .g   (regs[6]),
    .h   (regs[7]),
    .sel (addr),
    .out (y)
  );

endmodule

// File: tb/tb_ram8_16.sv
// tb_ram8_16: table-driven vectors, hand sequences for the sweep corner cases,
// and randomized traffic checked against a behavioural model.
module tb_ram8_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [15:0] d = 16'h0000;
  logic [15:0] y;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model: word array plus number of sweep cycles still to run.
  logic [15:0] m_mem [8];
  int          m_left = 0;

  typedef struct {
    logic        load;
    logic [2:0]  addr;
    logic [15:0] d;
    logic [15:0] exp_y;
  } vec_t;

  vec_t vecs [30];

  ram8_16 dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .load (load),
    .addr (addr),
    .clr  (clr),
    .y    (y),
    .busy (busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Rising edge: advance the model with the inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
      m_left = 0;
    end else if (m_left > 0) begin
      m_mem[8 - m_left] = 16'h0000;
      m_left--;
    end else if (clr) begin
      m_left = 8;
    end else if (load) begin
      m_mem[addr] = d;
    end
    #1;
  endtask

  // Drive inputs away from the edge and let the read path settle.
  task automatic drive(input logic r, input logic l, input logic c,
                       input logic [2:0] a, input logic [15:0] dd);
    rst  = r;
    load = l;
    clr  = c;
    addr = a;
    d    = dd;
    #2;
  endtask

  task automatic chk_model(input string name);
    chk16({name, "_y"}, y, m_mem[addr]);
    chk1({name, "_busy"}, busy, m_left > 0);
  endtask

  initial begin
    // Vector table: reads after reset, writes (same-cycle read = old value),
    // readback, then load=0 / load=1 on addr 5.
    for (int i = 0; i < 8; i++) begin
      vecs[i]      = '{1'b0, 3'(i), 16'h0000, 16'h0000};
      vecs[8 + i]  = '{1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 16'h0000};
      vecs[16 + i] = '{1'b0, 3'(i), 16'h0000, 16'(16'h1111 * (i + 1))};
    end
    vecs[24] = '{1'b0, 3'd5, 16'hFFFF, 16'h6666};
    vecs[25] = '{1'b0, 3'd5, 16'h0000, 16'h6666};
    vecs[26] = '{1'b1, 3'd5, 16'hABCD, 16'h6666};
    vecs[27] = '{1'b0, 3'd5, 16'h0000, 16'hABCD};
    vecs[28] = '{1'b0, 3'd4, 16'h0000, 16'h5555};
    vecs[29] = '{1'b0, 3'd6, 16'h0000, 16'h7777};

    // Reset.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    tick();
    tick();

    for (int v = 0; v < 30; v++) begin
      drive(1'b0, vecs[v].load, 1'b0, vecs[v].addr, vecs[v].d);
      chk16($sformatf("vec%0d_y", v), y, vecs[v].exp_y);
      chk1($sformatf("vec%0d_busy", v), busy, 1'b0);
      tick();
    end

    // Sweep with preloaded bank; load during busy is ignored.
    drive(1'b0, 1'b1, 1'b0, 3'd5, 16'h6666);
    tick();
    drive(1'b0, 1'b0, 1'b1, 3'd7, 16'h0000);
    chk1("sweep_pre_busy", busy, 1'b0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h1234);
        chk16("sweep_reg0_cleared", y, 16'h0000);
      end else begin
        drive(1'b0, 1'b0, 1'b0, 3'd7, 16'h0000);
        if (c <= 7) chk16($sformatf("sweep_c%0d_reg7", c), y, 16'h8888);
      end
      chk1($sformatf("sweep_c%0d_busy", c), busy, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 3'd7, 16'h0000);
    chk1("sweep_end_busy", busy, 1'b0);
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 1'b0, 3'(a), 16'h0000);
      chk16($sformatf("sweep_after_a%0d", a), y, 16'h0000);
      tick();
    end

    // clr+load together: clear wins; second clr mid-sweep does not extend it.
    drive(1'b0, 1'b1, 1'b0, 3'd2, 16'h3333);
    tick();
    drive(1'b0, 1'b1, 1'b1, 3'd2, 16'hBEEF);
    tick();
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 1'b0, (c == 4), 3'd2, 16'h0000);
      if (c <= 3) chk16($sformatf("both_c%0d_reg2", c), y, 16'h3333);
      chk1($sformatf("both_c%0d_busy", c), busy, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 3'd2, 16'h0000);
    chk1("both_end_busy", busy, 1'b0);
    chk16("both_end_reg2", y, 16'h0000);
    tick();

    // Reset during sweep aborts it; a following write works.
    drive(1'b0, 1'b1, 1'b0, 3'd6, 16'h7777);
    tick();
    drive(1'b0, 1'b0, 1'b1, 3'd6, 16'h0000);
    tick();
    for (int c = 1; c <= 2; c++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd6, 16'h0000);
      chk1($sformatf("abort_c%0d_busy", c), busy, 1'b1);
      chk16($sformatf("abort_c%0d_reg6", c), y, 16'h7777);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 3'd6, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd6, 16'h0000);
    chk1("abort_busy", busy, 1'b0);
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 1'b0, 3'(a), 16'h0000);
      chk16($sformatf("abort_a%0d", a), y, 16'h0000);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 3'd4, 16'h00FF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd4, 16'h0000);
    chk16("abort_write", y, 16'h00FF);
    chk1("abort_write_busy", busy, 1'b0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
            16'($urandom));
      chk_model($sformatf("rand%0d", n));
      tick();
    end

    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
